// File: rtl/write_back_stage.sv
// ---------------------------------------------------------------------------
// write_back_stage
//
// Final (WB) stage of the 5-stage MIPS pipeline. It takes retiring MEM-stage
// results, picks either the ALU result or the (extracted and extended) load
// data, and drives a registered write port into the register file. Pair
// results (HI/LO style) are written over two consecutive cycles: LO to
// dest_addr, then HI to dest_addr+1. The stage also counts accepted
// instructions.
//
// Ports:
//   clk            pipeline clock, all state changes on the rising edge
//   reset          synchronous, active-high reset
//   valid_in       MEM stage presents a retiring instruction
//   ready_out      stage can accept (IDLE and not in reset)
//   reg_write_in   instruction writes a register
//   mem_to_reg     1 = load data, 0 = alu_result
//   alu_result     ALU result (LO word for pair writes)
//   hi_result      HI word for pair writes
//   mem_data       raw word read from data memory
//   load_size      00 word, 01 half, 10 byte, 11 word
//   load_unsigned  1 = zero-extend, 0 = sign-extend
//   byte_offset    address[1:0] of the load
//   pair_in        two-register write (LO then HI)
//   dest_addr      destination register
//   result_write   data to register file
//   write_addr     register file write address
//   register_write register file write enable
//   retired_count  accepted-instruction count (saturating)
// ---------------------------------------------------------------------------
module write_back_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic              reg_write_in,
    input  logic              mem_to_reg,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] hi_result,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [1:0]        load_size,
    input  logic              load_unsigned,
    input  logic [1:0]        byte_offset,
    input  logic              pair_in,
    input  logic [ADDR_W-1:0] dest_addr,
    output logic [DATA_W-1:0] result_write,
    output logic [ADDR_W-1:0] write_addr,
    output logic              register_write,
    output logic [CNT_W-1:0]  retired_count
);

    typedef enum logic {
        IDLE,
        PAIR_HI
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [DATA_W-1:0] hi_data;
    logic [ADDR_W-1:0] hi_addr;
    logic [DATA_W-1:0] hi_data_next;
    logic [ADDR_W-1:0] hi_addr_next;

    logic [DATA_W-1:0] result_next;
    logic [ADDR_W-1:0] addr_next;
    logic              write_next;
    logic [CNT_W-1:0]  count_next;

    logic              accept;
    logic              start_pair;
    logic [15:0]       half_lane;
    logic [7:0]        byte_lane;
    logic [DATA_W-1:0] load_value;
    logic [DATA_W-1:0] select_value;
    logic [ADDR_W-1:0] pair_hi_addr;

    assign ready_out  = (state == IDLE) && !reset;
    assign accept     = valid_in && ready_out;

    // Only ALU-produced pair results get the two-cycle treatment; a pair flag
    // on a load or on a non-writing instruction is a plain single instruction.
    assign start_pair = pair_in && reg_write_in && !mem_to_reg;

    // Natural ADDR_W-bit wrap: a pair at the top register sends HI to $0,
    // where the write enable rule then suppresses it.
    assign pair_hi_addr = dest_addr + {{(ADDR_W-1){1'b0}}, 1'b1};

    // Load lane extraction: halves ignore byte_offset[0]; bytes use
    // little-endian lane numbering.
    always_comb begin
        half_lane  = byte_offset[1] ? mem_data[31:16] : mem_data[15:0];
        byte_lane  = mem_data[7:0];
        case (byte_offset)
            2'd0:    byte_lane = mem_data[7:0];
            2'd1:    byte_lane = mem_data[15:8];
            2'd2:    byte_lane = mem_data[23:16];
            default: byte_lane = mem_data[31:24];
        endcase

        load_value = mem_data;
        case (load_size)
            2'b01:   load_value = {{(DATA_W-16){half_lane[15] & !load_unsigned}}, half_lane};
            2'b10:   load_value = {{(DATA_W-8){byte_lane[7] & !load_unsigned}}, byte_lane};
            default: load_value = mem_data;
        endcase

        select_value = mem_to_reg ? load_value : alu_result;
    end

    // Next-state and next-output logic. Outside of an accept or the HI cycle
    // the data/address simply hold and the write enable drops.
    always_comb begin
        state_next   = state;
        hi_data_next = hi_data;
        hi_addr_next = hi_addr;
        result_next  = result_write;
        addr_next    = write_addr;
        write_next   = 1'b0;
        count_next   = retired_count;

        if (accept && (retired_count != {CNT_W{1'b1}})) begin
            count_next = retired_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    result_next = select_value;
                    addr_next   = dest_addr;
                    write_next  = reg_write_in && (dest_addr != '0);
                    if (start_pair) begin
                        hi_data_next = hi_result;
                        hi_addr_next = pair_hi_addr;
                        state_next   = PAIR_HI;
                    end
                end
            end
            PAIR_HI: begin
                result_next = hi_data;
                addr_next   = hi_addr;
                write_next  = (hi_addr != '0);
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers. Reset in the HI cycle drops the pending HI
    // write because the outputs are cleared at that same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            hi_data        <= '0;
            hi_addr        <= '0;
            result_write   <= '0;
            write_addr     <= '0;
            register_write <= 1'b0;
            retired_count  <= '0;
        end else begin
            state          <= state_next;
            hi_data        <= hi_data_next;
            hi_addr        <= hi_addr_next;
            result_write   <= result_next;
            write_addr     <= addr_next;
            register_write <= write_next;
            retired_count  <= count_next;
        end
    end

endmodule

// File: tb/tb_write_back_stage.sv
// ---------------------------------------------------------------------------
// tb_write_back_stage
//
// Self-checking bench for write_back_stage. A behavioural model treats the
// stage as a queue of pending register-file writes: an accept produces one
// write (plus a queued HI write for pairs), and exactly one write leaves per
// cycle. Directed steps cover reset, ALU ops, the four load extractions,
// $0 writes, pair sequencing with backpressure, pair wrap, and reset during
// a pair; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_write_back_stage;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic        ready_out;
    logic        reg_write_in;
    logic        mem_to_reg;
    logic [31:0] alu_result;
    logic [31:0] hi_result;
    logic [31:0] mem_data;
    logic [1:0]  load_size;
    logic        load_unsigned;
    logic [1:0]  byte_offset;
    logic        pair_in;
    logic [4:0]  dest_addr;
    logic [31:0] result_write;
    logic [4:0]  write_addr;
    logic        register_write;
    logic [31:0] retired_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        we;
    } write_t;

    write_t      pending[$];
    logic [31:0] m_result;
    logic [4:0]  m_addr;
    logic        m_we;
    logic [31:0] m_count;

    write_back_stage dut (
        .clk            (clk),
        .reset          (reset),
        .valid_in       (valid_in),
        .ready_out      (ready_out),
        .reg_write_in   (reg_write_in),
        .mem_to_reg     (mem_to_reg),
        .alu_result     (alu_result),
        .hi_result      (hi_result),
        .mem_data       (mem_data),
        .load_size      (load_size),
        .load_unsigned  (load_unsigned),
        .byte_offset    (byte_offset),
        .pair_in        (pair_in),
        .dest_addr      (dest_addr),
        .result_write   (result_write),
        .write_addr     (write_addr),
        .register_write (register_write),
        .retired_count  (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic rw, input logic m2r,
                                 input logic [31:0] alu, input logic [31:0] hi,
                                 input logic [31:0] mem, input logic [1:0] size,
                                 input logic uns, input logic [1:0] off,
                                 input logic pair, input logic [4:0] dest);
        valid_in      = v;
        reg_write_in  = rw;
        mem_to_reg    = m2r;
        alu_result    = alu;
        hi_result     = hi;
        mem_data      = mem;
        load_size     = size;
        load_unsigned = uns;
        byte_offset   = off;
        pair_in       = pair;
        dest_addr     = dest;
    endtask

    // Reference value of the write data, straight from the select/extract rules.
    function automatic logic [31:0] model_data(input logic m2r, input logic [31:0] alu,
                                               input logic [31:0] mem, input logic [1:0] size,
                                               input logic uns, input logic [1:0] off);
        logic [31:0] lane;
        if (!m2r) return alu;
        if (size == 2'b01) begin
            lane = (mem >> (16 * int'(off[1]))) & 32'h0000_FFFF;
            if (!uns && lane >= 32'h0000_8000) lane = lane + 32'hFFFF_0000;
            return lane;
        end
        if (size == 2'b10) begin
            lane = (mem >> (8 * int'(off))) & 32'h0000_00FF;
            if (!uns && lane >= 32'h0000_0080) lane = lane + 32'hFFFF_FF00;
            return lane;
        end
        return mem;
    endfunction

    // Advance one clock: check ready before the edge, update the model at
    // the edge, then check every registered output just after it.
    task automatic tick();
        logic        exp_ready;
        logic        accepted;
        logic [31:0] data;
        logic [4:0]  hi_addr;
        write_t      w;
        #1;
        exp_ready = !reset && (pending.size() == 0);
        checkOutput("ready_out", {31'd0, ready_out}, {31'd0, exp_ready});
        accepted = valid_in && exp_ready;
        data     = model_data(mem_to_reg, alu_result, mem_data, load_size,
                              load_unsigned, byte_offset);
        hi_addr  = dest_addr + 5'd1;
        @(posedge clk);
        if (reset) begin
            pending.delete();
            m_result = '0;
            m_addr   = '0;
            m_we     = 1'b0;
            m_count  = '0;
        end else if (pending.size() > 0) begin
            w        = pending.pop_front();
            m_result = w.data;
            m_addr   = w.addr;
            m_we     = w.we;
        end else if (accepted) begin
            m_result = data;
            m_addr   = dest_addr;
            m_we     = reg_write_in && (dest_addr != 5'd0);
            if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
            if (pair_in && reg_write_in && !mem_to_reg) begin
                w.data = hi_result;
                w.addr = hi_addr;
                w.we   = (hi_addr != 5'd0);
                pending.push_back(w);
            end
        end else begin
            m_we = 1'b0;
        end
        #1;
        checkOutput("result_write", result_write, m_result);
        checkOutput("write_addr", {27'd0, write_addr}, {27'd0, m_addr});
        checkOutput("register_write", {31'd0, register_write}, {31'd0, m_we});
        checkOutput("retired_count", retired_count, m_count);
    endtask

    initial begin
        m_result = '0;
        m_addr   = '0;
        m_we     = 1'b0;
        m_count  = '0;
        reset    = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 5'd0);

        // Reset held for two cycles, then released.
        tick();
        tick();
        reset = 1'b0;
        tick();
        checkOutput("reset_result", result_write, 32'h0);
        checkOutput("reset_count", retired_count, 32'h0);
        checkOutput("ready_after_reset", {31'd0, ready_out}, 32'd1);

        // ALU op.
        applyStimulus(1, 1, 0, 32'h1234_5678, 0, 0, 2'b00, 0, 2'b00, 0, 5'd8);
        tick();
        checkOutput("alu_data", result_write, 32'h1234_5678);
        checkOutput("alu_addr", {27'd0, write_addr}, 32'd8);
        checkOutput("alu_we", {31'd0, register_write}, 32'd1);
        checkOutput("alu_count", retired_count, 32'd1);

        // Load extraction from 0x80FF_7F01.
        applyStimulus(1, 1, 1, 0, 0, 32'h80FF_7F01, 2'b10, 0, 2'd2, 0, 5'd3);
        tick();
        checkOutput("lb_off2", result_write, 32'hFFFF_FFFF);
        applyStimulus(1, 1, 1, 0, 0, 32'h80FF_7F01, 2'b10, 1, 2'd0, 0, 5'd3);
        tick();
        checkOutput("lbu_off0", result_write, 32'h0000_0001);
        applyStimulus(1, 1, 1, 0, 0, 32'h80FF_7F01, 2'b01, 0, 2'd2, 0, 5'd3);
        tick();
        checkOutput("lh_off2", result_write, 32'hFFFF_80FF);
        applyStimulus(1, 1, 1, 0, 0, 32'h80FF_7F01, 2'b01, 1, 2'd0, 0, 5'd3);
        tick();
        checkOutput("lhu_off0", result_write, 32'h0000_7F01);

        // Write to $0 is suppressed but still retires.
        applyStimulus(1, 1, 0, 32'hDEAD_BEEF, 0, 0, 2'b00, 0, 2'b00, 0, 5'd0);
        tick();
        checkOutput("zero_we", {31'd0, register_write}, 32'd0);
        checkOutput("zero_addr", {27'd0, write_addr}, 32'd0);
        checkOutput("zero_count", retired_count, 32'd6);

        // Idle cycle.
        applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 5'd0);
        tick();

        // Pair at 30 with the next instruction held behind it.
        applyStimulus(1, 1, 0, 32'hAAAA_0000, 32'h0000_BBBB, 0, 2'b00, 0, 2'b00, 1, 5'd30);
        tick();
        checkOutput("pair_lo_data", result_write, 32'hAAAA_0000);
        checkOutput("pair_lo_addr", {27'd0, write_addr}, 32'd30);
        checkOutput("pair_ready_low", {31'd0, ready_out}, 32'd0);
        applyStimulus(1, 1, 0, 32'h0000_0055, 0, 0, 2'b00, 0, 2'b00, 0, 5'd5);
        tick();
        checkOutput("pair_hi_data", result_write, 32'h0000_BBBB);
        checkOutput("pair_hi_addr", {27'd0, write_addr}, 32'd31);
        checkOutput("pair_hi_we", {31'd0, register_write}, 32'd1);
        checkOutput("pair_count", retired_count, 32'd7);
        tick();
        checkOutput("after_pair_addr", {27'd0, write_addr}, 32'd5);
        checkOutput("after_pair_count", retired_count, 32'd8);

        // Pair at 31: HI wraps to $0 and is suppressed.
        applyStimulus(1, 1, 0, 32'h1111_1111, 32'h2222_2222, 0, 2'b00, 0, 2'b00, 1, 5'd31);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 5'd0);
        tick();
        checkOutput("wrap_addr", {27'd0, write_addr}, 32'd0);
        checkOutput("wrap_we", {31'd0, register_write}, 32'd0);

        // Reset during the HI cycle drops the HI write.
        applyStimulus(1, 1, 0, 32'h3333_3333, 32'h4444_4444, 0, 2'b00, 0, 2'b00, 1, 5'd10);
        tick();
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 5'd0);
        tick();
        checkOutput("rst_pair_data", result_write, 32'h0);
        checkOutput("rst_pair_we", {31'd0, register_write}, 32'd0);
        checkOutput("rst_pair_count", retired_count, 32'd0);
        reset = 1'b0;
        tick();

        // Randomized phase against the model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                          $urandom_range(0, 1), $urandom, $urandom, $urandom,
                          2'($urandom_range(0, 3)), $urandom_range(0, 1),
                          2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
                          5'($urandom_range(0, 31)));
            reset = ($urandom_range(0, 49) == 0);
            tick();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/write_back_stage.md
Name: write_back_stage

Overview:
- Final (WB) stage of the 5-stage MIPS pipeline; the producer end of the decode stage's register-file write port.
- Takes retiring MEM-stage results and selects ALU result or load data, with byte/half extraction and sign/zero extension.
- Drives registered result_write / write_addr / register_write into the register file.
- Sequences two-register writes (HI/LO-style pair results) over two cycles with a ready handshake; keeps a retired-instruction counter.

Parameters:
- DATA_W, 32, datapath width.
- ADDR_W, 5, register address width.
- CNT_W, 32, retired-counter width.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- valid_in  input  1  MEM stage presents a retiring instruction
- ready_out  output  1  stage can accept; 1 only in IDLE and not in reset
- reg_write_in  input  1  instruction writes a register
- mem_to_reg  input  1  1 = load data, 0 = alu_result
- alu_result  input  32  ALU result; the LO word for pair writes
- hi_result  input  32  HI word for pair writes
- mem_data  input  32  raw word read from data memory
- load_size  input  2  00 word, 01 half, 10 byte, 11 treated as word
- load_unsigned  input  1  1 = zero-extend, 0 = sign-extend
- byte_offset  input  2  address[1:0] of the load
- pair_in  input  1  write alu_result to dest_addr, then hi_result to dest_addr+1
- dest_addr  input  5  destination register
- result_write  output  32  data to register file
- write_addr  output  5  register file write address
- register_write  output  1  register file write enable
- retired_count  output  32  accepted-instruction count

Behaviour:
- Clock is clk. Reset is synchronous and active-high, sampled on the clk rising edge.
- Reset effects:
  - result_write = 0, write_addr = 0, register_write = 0, retired_count = 0.
  - State = IDLE.
  - ready_out is 0 while reset is high.
- Accept condition: valid_in & ready_out at a rising edge. All outputs are registered with 1-cycle latency from accept.
- Cycle with no accept in IDLE: register_write = 0 next cycle. result_write and write_addr hold their last values.
- Data select:
  - mem_to_reg = 0: result = alu_result.
  - mem_to_reg = 1, load_size 00 or 11: full word.
  - mem_to_reg = 1, load_size 01: half = mem_data[16*byte_offset[1] +: 16]; byte_offset[0] is ignored.
  - mem_to_reg = 1, load_size 10: byte = mem_data[8*byte_offset +: 8] (little-endian lanes).
  - Extension: zero-extend if load_unsigned = 1, otherwise sign-extend from the lane MSB.
- Write-enable rule: register_write = reg_write_in & (target address != 0). result_write and write_addr are still updated when the write is suppressed.
- FSM states: IDLE, PAIR_HI.
  - IDLE, accept with pair_in & reg_write_in & !mem_to_reg:
    - Latch hi_result and dest_addr+1 (5-bit wrap; 31 wraps to 0).
    - Emit the LO write to dest_addr next cycle.
    - Go to PAIR_HI; ready_out = 0.
  - PAIR_HI:
    - Emit the HI write (latched value and address). Address 0 after wrap means register_write = 0.
    - Return to IDLE; ready_out = 1 in the following cycle.
  - pair_in with mem_to_reg = 1 or reg_write_in = 0: treated as a normal single instruction.
- Backpressure: inputs presented while ready_out = 0 are ignored. Upstream holds them until accepted.
- retired_count:
  - +1 per accept, including accepts with reg_write_in = 0.
  - The PAIR_HI cycle does not count.
  - Saturates at all-ones.
- Reset during PAIR_HI: the HI write is dropped. State = IDLE and outputs are cleared at that edge.
- Ordering for decode: the register file sees exactly one write per cycle. The HI write always follows the LO write by exactly one cycle.

Test Plan:
- Reset high 2 cycles, then low -> all outputs 0, ready_out = 1 one cycle after deassert, retired_count = 0.
- ALU op: alu_result = 0x1234_5678, dest 8, reg_write_in = 1 -> next cycle register_write = 1, write_addr = 8, result_write = 0x1234_5678, retired_count = 1.
- Loads from mem_data = 0x80FF_7F01:
  - byte, offset 2, signed -> 0xFFFF_FFFF.
  - byte, offset 0, unsigned -> 0x0000_0001.
  - half, offset 2, signed -> 0xFFFF_80FF.
  - half, offset 0, unsigned -> 0x0000_7F01.
- Write to $0: dest 0, reg_write_in = 1 -> register_write = 0, write_addr = 0, retired_count still increments.
- Pair write: alu = 0xAAAA_0000, hi = 0x0000_BBBB, dest 30, valid_in held high with a next instruction pending:
  - Cycle 1: write 30 <- 0xAAAA_0000, ready_out = 0.
  - Cycle 2: write 31 <- 0x0000_BBBB.
  - The next instruction is accepted only after ready_out returns to 1.
  - retired_count +1 for the pair.
- Pair at dest 31 -> HI write goes to address 0 with register_write = 0. Separately, reset asserted in PAIR_HI -> no HI write, all outputs 0.
